// File: rtl/bin2bcd_seq.sv
// Sequential binary to 8421-BCD converter (shift-add-3), one input bit per clock.
// The last completed result stays on bcd/ovf so a display can read it at any time.
module bin2bcd_seq #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      bin,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  ovf,
   output logic                  busy,
   output logic [1:0]            state_dbg
);

   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [WIDTH-1:0] bin_sr_q, bin_sr_d;
   logic [BW-1:0]    work_q, work_d;
   logic             ovf_acc_q, ovf_acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [BW-1:0]    bcd_q, bcd_d;
   logic             ovf_q, ovf_d;

   logic [BW-1:0]    adj;
   logic [BW-1:0]    work_shift;
   logic             ovf_shift;
   logic             accept;

   // Handshake: a transfer happens on a rising edge where valid and ready are
   // both high. in_ready depends only on state and out_ready, never on
   // in_valid; out_valid stays high and bcd/ovf stay stable until out_ready.
   assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q == S_SHIFT);
   assign bcd       = bcd_q;
   assign ovf       = ovf_q;
   assign state_dbg = state_q;

   always_comb begin
      adj = work_q;
      for (int k = 0; k < DIGITS; k++) begin
         if (work_q[4*k +: 4] >= 4'd5) begin
            adj[4*k +: 4] = work_q[4*k +: 4] + 4'd3;
         end
      end
   end

   // The bit leaving the top digit is worth 10^DIGITS, so it only flags overflow.
   assign work_shift = {adj[BW-2:0], bin_sr_q[WIDTH-1]};
   assign ovf_shift  = ovf_acc_q | adj[BW-1];

   always_comb begin
      state_d   = state_q;
      bin_sr_d  = bin_sr_q;
      work_d    = work_q;
      ovf_acc_d = ovf_acc_q;
      cnt_d     = cnt_q;
      bcd_d     = bcd_q;
      ovf_d     = ovf_q;

      case (state_q)
         S_IDLE: begin
            state_d = S_IDLE;
         end
         S_SHIFT: begin
            work_d    = work_shift;
            bin_sr_d  = bin_sr_q << 1;
            ovf_acc_d = ovf_shift;
            cnt_d     = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = S_DONE;
               bcd_d   = work_shift;
               ovf_d   = ovf_shift;
            end
         end
         S_DONE: begin
            if (out_ready && !in_valid) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // accept is only possible in IDLE or DONE, never while shifting.
      if (accept) begin
         state_d   = S_SHIFT;
         bin_sr_d  = bin;
         work_d    = '0;
         ovf_acc_d = 1'b0;
         cnt_d     = CW'(WIDTH);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         bin_sr_q  <= '0;
         work_q    <= '0;
         ovf_acc_q <= 1'b0;
         cnt_q     <= '0;
         bcd_q     <= '0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         bin_sr_q  <= bin_sr_d;
         work_q    <= work_d;
         ovf_acc_q <= ovf_acc_d;
         cnt_q     <= cnt_d;
         bcd_q     <= bcd_d;
         ovf_q     <= ovf_d;
      end
   end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: a 4-digit instance for handshake/latency
// scenarios and a 2-digit instance for overflow behaviour.
module tb_bin2bcd_seq;

   logic        clk = 1'b0;
   logic        reset;

   logic        in_valid, in_ready, out_valid, out_ready, ovf, busy;
   logic [7:0]  bin;
   logic [15:0] bcd;
   logic [1:0]  state_dbg;

   logic        in_valid_2, in_ready_2, out_valid_2, out_ready_2, ovf_2, busy_2;
   logic [7:0]  bin_2;
   logic [7:0]  bcd_2;
   logic [1:0]  state_dbg_2;

   int          n_checks = 0;
   int          n_pass   = 0;
   int          n_fail   = 0;
   logic [15:0] exp_q[$];

   // clock / reset
   always #5 clk = ~clk;

   bin2bcd_seq #(.WIDTH(8), .DIGITS(4)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .bin(bin),
      .out_valid(out_valid), .out_ready(out_ready),
      .bcd(bcd), .ovf(ovf), .busy(busy), .state_dbg(state_dbg)
   );

   bin2bcd_seq #(.WIDTH(8), .DIGITS(2)) dut_2 (
      .clk(clk), .reset(reset),
      .in_valid(in_valid_2), .in_ready(in_ready_2), .bin(bin_2),
      .out_valid(out_valid_2), .out_ready(out_ready_2),
      .bcd(bcd_2), .ovf(ovf_2), .busy(busy_2), .state_dbg(state_dbg_2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // drivers: start_conv is the accepting edge (edge 1), finish_conv runs edges 2..9
   task automatic start_conv(input logic [7:0] b, input logic [15:0] e);
      exp_q.push_back(e);
      bin      = b;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      bin      = 8'($urandom_range(0, 255));
      check("accept_busy", {31'd0, busy}, 32'd1);
      check("accept_in_ready", {31'd0, in_ready}, 32'd0);
   endtask

   task automatic finish_conv(input string tag);
      logic [15:0] e;
      for (int i = 2; i <= 8; i++) begin
         tick();
         check({tag, "_early_valid"}, {31'd0, out_valid}, 32'd0);
         check({tag, "_shift_ready"}, {31'd0, in_ready}, 32'd0);
      end
      tick();
      e = exp_q.pop_front();
      check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_bcd"}, {16'd0, bcd}, {16'd0, e});
      check({tag, "_ovf"}, {31'd0, ovf}, 32'd0);
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
   endtask

   task automatic conv2(input string tag, input logic [7:0] b, input logic [7:0] e, input logic eo);
      bin_2      = b;
      in_valid_2 = 1'b1;
      tick();
      in_valid_2 = 1'b0;
      repeat (7) tick();
      check({tag, "_early_valid"}, {31'd0, out_valid_2}, 32'd0);
      tick();
      check({tag, "_valid"}, {31'd0, out_valid_2}, 32'd1);
      check({tag, "_bcd"}, {24'd0, bcd_2}, {24'd0, e});
      check({tag, "_ovf"}, {31'd0, ovf_2}, {31'd0, eo});
      out_ready_2 = 1'b1;
      tick();
      out_ready_2 = 1'b0;
      check({tag, "_consumed"}, {31'd0, out_valid_2}, 32'd0);
   endtask

   initial begin
      reset       = 1'b1;
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      bin         = 8'd0;
      in_valid_2  = 1'b0;
      out_ready_2 = 1'b0;
      bin_2       = 8'd0;
      tick();
      tick();
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_bcd", {16'd0, bcd}, 32'd0);
      check("rst_ovf", {31'd0, ovf}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      reset = 1'b0;
      tick();

      // zero input, out_ready low
      start_conv(8'd0, 16'h0000);
      finish_conv("zero");
      out_ready = 1'b1;
      tick();
      check("zero_consumed", {31'd0, out_valid}, 32'd0);

      // 225 with out_ready high: result valid exactly one cycle
      start_conv(8'd225, 16'h0225);
      finish_conv("p225");
      tick();
      check("p225_one_cycle", {31'd0, out_valid}, 32'd0);
      check("p225_idle", {30'd0, state_dbg}, 32'd0);
      check("p225_held", {16'd0, bcd}, 32'h0225);

      // 255 held with out_ready low; in_valid pulses ignored
      out_ready = 1'b0;
      start_conv(8'd255, 16'h0255);
      finish_conv("p255");
      for (int i = 0; i < 12; i++) begin
         in_valid = (i % 3 == 0);
         bin      = 8'd7;
         tick();
         check("hold_valid", {31'd0, out_valid}, 32'd1);
         check("hold_bcd", {16'd0, bcd}, 32'h0255);
         check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      check("release_valid", {31'd0, out_valid}, 32'd0);
      check("release_in_ready", {31'd0, in_ready}, 32'd1);
      start_conv(8'd64, 16'h0064);
      finish_conv("p64");
      tick();

      // back-to-back 42 then 99
      bin      = 8'd42;
      in_valid = 1'b1;
      tick();
      bin = 8'd99;
      for (int i = 2; i <= 8; i++) begin
         tick();
         check("b2b_early", {31'd0, out_valid}, 32'd0);
      end
      tick();
      check("b2b_42_valid", {31'd0, out_valid}, 32'd1);
      check("b2b_42_bcd", {16'd0, bcd}, 32'h0042);
      check("b2b_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      bin      = 8'd3;
      check("b2b_consumed", {31'd0, out_valid}, 32'd0);
      check("b2b_busy", {31'd0, busy}, 32'd1);
      for (int i = 11; i <= 17; i++) begin
         tick();
         check("b2b_old_bcd", {16'd0, bcd}, 32'h0042);
      end
      tick();
      check("b2b_99_valid", {31'd0, out_valid}, 32'd1);
      check("b2b_99_bcd", {16'd0, bcd}, 32'h0099);
      tick();

      // reset during conversion of 200 at edge 4
      bin      = 8'd200;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      tick();
      #2;
      reset = 1'b1;
      #1;
      check("arst_bcd", {16'd0, bcd}, 32'd0);
      check("arst_valid", {31'd0, out_valid}, 32'd0);
      check("arst_busy", {31'd0, busy}, 32'd0);
      tick();
      reset = 1'b0;
      start_conv(8'd13, 16'h0013);
      finish_conv("p13");
      tick();

      // two-digit instance: overflow wraps modulo 100
      conv2("d2_99", 8'd99, 8'h99, 1'b0);
      conv2("d2_200", 8'd200, 8'h00, 1'b1);
      conv2("d2_7", 8'd7, 8'h07, 1'b0);
      conv2("d2_150", 8'd150, 8'h50, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
